// File: rtl/bist_pkg.sv
// Shared constants and helpers for the BIST datapath slice.
package bist_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam int   ERR_CNT_W = 8;

  // Smallest r such that 2**r >= n; used to size address buses from DEPTH.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bist_addr_cnt.sv
// March-test address counter: loads, up/down stepping over 0..DEPTH-1, registered wrap pulse.
module bist_addr_cnt
  import bist_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rst_adr_i,
  input  logic          pr_res_adr_i,
  input  logic          enable_i,
  input  logic          up_down_i,
  output logic [AW-1:0] addr_o,
  output logic          c_out_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] addr_q, addr_d;
  logic          c_out_q, c_out_d;

  // Loads outrank stepping and never raise the wrap pulse.
  always_comb begin
    addr_d  = addr_q;
    c_out_d = 1'b0;
    if (rst_adr_i) begin
      addr_d = '0;
    end else if (pr_res_adr_i) begin
      addr_d = LAST;
    end else if (enable_i) begin
      if (up_down_i == DIR_UP) begin
        if (addr_q == LAST) begin
          addr_d  = '0;
          c_out_d = 1'b1;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end else begin
        if (addr_q == '0) begin
          addr_d  = LAST;
          c_out_d = 1'b1;
        end else begin
          addr_d = addr_q - AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      c_out_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      c_out_q <= c_out_d;
    end
  end

  assign addr_o  = addr_q;
  assign c_out_o = c_out_q;

endmodule

// File: rtl/bist_datapath.sv
// BIST datapath: executes controller commands on the memory under test and
// checks read-back data against the solid data background.
module bist_datapath
  import bist_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = clog2(DEPTH),
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rst_adr,
  input  logic                 pr_res_adr,
  input  logic                 enable,
  input  logic                 up_down,
  input  logic                 data_bit,
  input  logic                 wr_en,
  input  logic                 read_en,
  output logic                 c_out,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 fail,
  output logic [AW-1:0]        fail_addr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  bist_addr_cnt #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_addr_cnt (
    .clk_i        (clk),
    .rst_i        (rst),
    .rst_adr_i    (rst_adr),
    .pr_res_adr_i (pr_res_adr),
    .enable_i     (enable),
    .up_down_i    (up_down),
    .addr_o       (mem_addr),
    .c_out_o      (c_out)
  );

  // A simultaneous write and read resolves to the write; no compare is queued.
  assign mem_we    = wr_en;
  assign mem_re    = read_en & ~wr_en;
  assign mem_wdata = {DW{data_bit}};

  // Compare pipeline: stage i holds the read issued i+1 cycles ago.
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] exp_q;
  logic [AW-1:0]     paddr_q [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      exp_q <= '0;
      for (int i = 0; i < RD_LAT; i++) paddr_q[i] <= '0;
    end else begin
      vld_q[0]   <= mem_re;
      exp_q[0]   <= data_bit;
      paddr_q[0] <= mem_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]   <= vld_q[i-1];
        exp_q[i]   <= exp_q[i-1];
        paddr_q[i] <= paddr_q[i-1];
      end
    end
  end

  logic                 mismatch;
  logic                 fail_q, fail_d;
  logic [AW-1:0]        fail_addr_q, fail_addr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign mismatch = vld_q[RD_LAT-1] & (mem_rdata != {DW{exp_q[RD_LAT-1]}});

  // fail is sticky and fail_addr keeps only the first offending address.
  always_comb begin
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    err_cnt_d   = err_cnt_q;
    if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) fail_addr_d = paddr_q[RD_LAT-1];
      if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign err_cnt   = err_cnt_q;

endmodule
